// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one data memory between an
// instruction-fetch port (I) and a load/store port (D).
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_req/i_addr                    fetch request (word read)
//   i_ack/i_err/i_rdata             fetch completion, misalign flag, data
//   d_req/d_we/d_funct3/d_addr/     data request, RISC-V funct3,
//   d_wdata                         byte address, store data
//   d_ack/d_err/d_rdata             data completion, misalign flag, data
//   mem_read/mem_write/mem_funct3/  shared memory command, driven only
//   mem_addr/mem_wdata              while an access is in flight
//   mem_rdata                       combinational memory read data
module mem_arbiter #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_err,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // last_q/own_q: 0 = I port, 1 = D port
  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic              own_q, own_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d;
  logic [31:0]       wd_q, wd_d;
  logic [31:0]       rd_q, rd_d;
  logic              err_q, err_d;

  logic              pick_d;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_f3;
  logic              sel_we;
  logic [31:0]       sel_wd;
  logic              mis;

  // D wins when alone, or on a tie when I was granted last
  assign pick_d   = d_req & (~i_req | ~last_q);
  assign sel_addr = pick_d ? d_addr : i_addr;
  assign sel_f3   = pick_d ? d_funct3 : 3'b010;
  assign sel_we   = pick_d & d_we;
  assign sel_wd   = pick_d ? d_wdata : 32'd0;

  always_comb begin
    mis = 1'b0;
    case (sel_f3[1:0])
      2'b10:   mis = (sel_addr[1:0] != 2'b00);
      2'b01:   mis = sel_addr[0];
      default: mis = 1'b0;
    endcase
    // reserved encodings, and unsigned loads used as stores
    if (sel_f3 == 3'b011 || sel_f3[2:1] == 2'b11) mis = 1'b1;
    if (sel_f3[2:1] == 2'b10 && sel_we) mis = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    own_d   = own_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    we_d    = we_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_req | d_req) begin
          own_d   = pick_d;
          last_d  = pick_d;
          addr_d  = sel_addr;
          f3_d    = sel_f3;
          we_d    = sel_we;
          wd_d    = sel_wd;
          rd_d    = 32'd0;
          err_d   = mis;
          state_d = mis ? S_RESP : S_ACC;
        end
      end
      S_ACC: begin
        rd_d    = we_q ? 32'd0 : mem_rdata;
        state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b0;
      own_q   <= 1'b0;
      addr_q  <= '0;
      f3_q    <= 3'd0;
      we_q    <= 1'b0;
      wd_q    <= 32'd0;
      rd_q    <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      own_q   <= own_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  logic acc, resp;
  assign acc  = (state_q == S_ACC);
  assign resp = (state_q == S_RESP);

  assign mem_read   = acc & ~we_q;
  assign mem_write  = acc & we_q;
  assign mem_addr   = acc ? addr_q : '0;
  assign mem_funct3 = acc ? f3_q : 3'd0;
  assign mem_wdata  = acc ? wd_q : 32'd0;

  assign i_ack   = resp & ~own_q;
  assign i_err   = i_ack & err_q;
  assign i_rdata = i_ack ? rd_q : 32'd0;
  assign d_ack   = resp & own_q;
  assign d_err   = d_ack & err_q;
  assign d_rdata = d_ack ? rd_q : 32'd0;

endmodule
